// File: rtl/irq_dispatch_pkg.sv
// Shared types and constants for the interrupt dispatcher: FSM encoding,
// interrupt code width and the code-to-vector mapping used by the counter.
package irq_dispatch_pkg;

  localparam int CODE_W   = 3;
  localparam int VEC_BASE = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2,
    GAP  = 2'd3
  } state_t;

  typedef logic [CODE_W-1:0] code_t;

  // Code c lands on vector c+1, so code 1 is the first vector at VEC_BASE.
  function automatic logic [3:0] code_to_vec(code_t c);
    return 4'(c) + 4'(VEC_BASE - 1);
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Single-bit synchroniser of SYNC_STAGES flops followed by a rising-edge
// detector; rise is high for exactly one cycle per low-to-high transition.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage take the previous
      // stage's old value, so the loop order does not matter.
      chain[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign rise = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt initiator: latches source edges, masks them, presents the
// highest-priority code to the counter and sequences REQ/SVC/GAP handshakes.
module irq_dispatch
  import irq_dispatch_pkg::*;
#(
  parameter int NSRC        = 7,
  parameter int SYNC_STAGES = 2,
  parameter int REQ_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  output logic [NSRC-1:0] mask,
  output logic [NSRC-1:0] pending,
  input  logic            inter,
  input  logic            eirq,
  output logic            irq1,
  output logic            irq2,
  output logic            irq3,
  output logic            busy,
  output logic [2:0]      active
);

  localparam logic [7:0] TO_LAST = 8'(REQ_TIMEOUT - 1);

  state_t          state, state_n;
  code_t           active_n, winner;
  logic [7:0]      timer, timer_n;
  logic [NSRC-1:0] rise, clr_vec, pending_n, mask_n;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (src[g]),
      .rise (rise[g])
    );
  end

  // Highest index wins; source i is code i+1, code 0 means nothing to send.
  function automatic code_t pick(logic [NSRC-1:0] req);
    code_t c = '0;
    for (int i = 0; i < NSRC; i++) if (req[i]) c = code_t'(i + 1);
    return c;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    state_n  = state;
    active_n = active;
    timer_n  = timer;
    clr_vec  = '0;
    winner   = pick(pending & mask);

    case (state)
      IDLE: begin
        if (winner != '0) begin
          active_n = winner;
          timer_n  = '0;
          state_n  = REQ;
        end
      end
      REQ: begin
        if (inter) begin
          state_n = SVC;
        end else if (timer == TO_LAST) begin
          active_n = '0;
          state_n  = GAP;
        end else begin
          timer_n = timer + 8'd1;
        end
      end
      SVC: begin
        if (eirq) begin
          clr_vec  = NSRC'(1) << (active - code_t'(1));
          active_n = '0;
          state_n  = GAP;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // A fresh edge arriving with the retire keeps the source pending.
    pending_n = (pending & ~clr_vec) | rise;
    mask_n    = mask_we ? mask_wdata : mask;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      active  <= '0;
      timer   <= '0;
      pending <= '0;
      mask    <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      active  <= active_n;
      timer   <= timer_n;
      pending <= pending_n;
      mask    <= mask_n;
      busy    <= (state_n != IDLE);
    end
  end

  // active is zero outside REQ/SVC, so the code lines follow it directly.
  assign {irq3, irq2, irq1} = active;

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed bench for irq_dispatch: reset, dispatch, priority, timeout,
// re-edge during retire, mask change in service and reset mid-request.
module tb_irq_dispatch;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] src;
  logic       mask_we;
  logic [6:0] mask_wdata;
  logic [6:0] mask;
  logic [6:0] pending;
  logic       inter;
  logic       eirq;
  logic       irq1, irq2, irq3;
  logic       busy;
  logic [2:0] active;

  int n_checks = 0;
  int n_errors = 0;

  irq_dispatch #(.NSRC(7), .SYNC_STAGES(2), .REQ_TIMEOUT(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .src        (src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask),
    .pending    (pending),
    .inter      (inter),
    .eirq       (eirq),
    .irq1       (irq1),
    .irq2       (irq2),
    .irq3       (irq3),
    .busy       (busy),
    .active     (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs and samples both land 1 time unit after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [2:0] code();
    return {irq3, irq2, irq1};
  endfunction

  task automatic pulse_src(input logic [6:0] v);
    src = v;
    tick();
    src = '0;
  endtask

  task automatic pulse_inter();
    inter = 1'b1;
    tick();
    inter = 1'b0;
  endtask

  task automatic pulse_eirq();
    eirq = 1'b1;
    tick();
    eirq = 1'b0;
  endtask

  task automatic write_mask(input logic [6:0] v);
    mask_we    = 1'b1;
    mask_wdata = v;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
  endtask

  int cnt;

  initial begin
    rst = 1'b0; src = '0; mask_we = 1'b0; mask_wdata = '0; inter = 1'b0; eirq = 1'b0;
    tick();

    // Reset with all sources high
    src = 7'h7F;
    tick(3);
    check("rst_mask",    mask,    7'h00);
    check("rst_pending", pending, 7'h00);
    check("rst_code",    code(),  3'd0);
    check("rst_busy",    busy,    1'b0);
    check("rst_active",  active,  3'd0);
    src = '0;
    rst = 1'b1;
    tick(4);
    pulse_src(7'h01);
    tick(2);
    check("unmasked_pending", pending, 7'h01);
    tick();
    check("unmasked_code", code(), 3'd0);
    check("unmasked_busy", busy,   1'b0);

    // Single dispatch of src[2]
    do_reset();
    write_mask(7'h7F);
    check("mask_write", mask, 7'h7F);
    pulse_src(7'h04);
    tick();
    check("sd_pending_early", pending, 7'h00);
    tick();
    check("sd_pending",     pending, 7'h04);
    check("sd_active_idle", active,  3'd0);
    tick();
    check("sd_active", active, 3'd3);
    check("sd_code",   code(), 3'd3);
    check("sd_busy",   busy,   1'b1);
    tick(3);
    check("sd_hold", code(), 3'd3);
    pulse_inter();
    tick(2);
    check("sd_svc_code", code(), 3'd3);
    check("sd_svc_busy", busy,   1'b1);
    pulse_eirq();
    check("sd_gap_pending", pending, 7'h00);
    check("sd_gap_code",    code(),  3'd0);
    check("sd_gap_busy",    busy,    1'b1);
    tick();
    check("sd_idle_busy", busy,   1'b0);
    check("sd_idle_code", code(), 3'd0);

    // Priority: src[1] and src[5] together
    pulse_src(7'h22);
    tick(2);
    check("pr_pending", pending, 7'h22);
    tick();
    check("pr_first", code(), 3'd6);
    pulse_inter();
    pulse_eirq();
    check("pr_gap_pending", pending, 7'h02);
    check("pr_gap_code",    code(),  3'd0);
    tick();
    check("pr_idle_busy", busy, 1'b0);
    tick();
    check("pr_second", code(), 3'd2);
    pulse_inter();
    pulse_eirq();
    tick();
    check("pr_done_pending", pending, 7'h00);
    check("pr_done_busy",    busy,    1'b0);

    // Timeout on code 4 with no inter
    pulse_src(7'h08);
    tick(3);
    check("to_code", code(), 3'd4);
    cnt = 0;
    while (code() != 3'd0 && cnt < 300) begin
      tick();
      cnt++;
    end
    check("to_cycles",  cnt,        255);
    check("to_pending", pending[3], 1'b1);
    check("to_gap_busy", busy,      1'b1);
    tick();
    check("to_idle_busy", busy,   1'b0);
    check("to_idle_code", code(), 3'd0);
    tick();
    check("to_retry", code(), 3'd4);
    pulse_inter();
    pulse_eirq();
    tick();
    check("to_done_pending", pending, 7'h00);

    // New edge on src[0] lands on the same edge as its retire
    pulse_src(7'h01);
    tick(3);
    check("re_code", code(), 3'd1);
    pulse_inter();
    src = 7'h01;
    tick();
    src = '0;
    tick();
    pulse_eirq();
    check("re_pending", pending, 7'h01);
    check("re_gap_code", code(), 3'd0);
    tick();
    check("re_idle_busy", busy, 1'b0);
    tick();
    check("re_redispatch", code(), 3'd1);
    pulse_inter();
    pulse_eirq();
    tick();
    check("re_done_pending", pending, 7'h00);

    // Mask cleared while code 5 is in service
    pulse_src(7'h10);
    tick(3);
    check("mk_code", code(), 3'd5);
    pulse_inter();
    write_mask(7'h00);
    check("mk_mask", mask, 7'h00);
    tick(2);
    check("mk_active", active, 3'd5);
    pulse_eirq();
    check("mk_gap_active",  active,  3'd0);
    check("mk_gap_pending", pending, 7'h00);
    tick();

    // Reset while requesting code 2
    write_mask(7'h7F);
    pulse_src(7'h02);
    tick(3);
    check("rr_code", code(), 3'd2);
    rst = 1'b0;
    tick();
    check("rr_code_after",    code(),  3'd0);
    check("rr_pending_after", pending, 7'h00);
    check("rr_busy_after",    busy,    1'b0);
    check("rr_mask_after",    mask,    7'h00);
    rst = 1'b1;
    tick(2);
    check("rr_idle_code", code(), 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_dispatch.md
Name: irq_dispatch

Overview:
- Initiator side of the processor interrupt interface: collects up to 7 peripheral interrupt sources, latches and masks them, and presents the winner as the 3-bit code {irq3,irq2,irq1}.
- The counter maps that code to vector address 2..8.
- Holds the code until the counter reports service via inter, then waits for end-of-interrupt (eirq), retires the source and dispatches the next one.
- Sits between peripherals and the counter/program-flow block.

Parameters:
- NSRC, 7: number of sources; fixed maximum 7 (3-bit code, code 0 means none).
- SYNC_STAGES, 2: synchroniser depth on each src input, minimum 1.
- REQ_TIMEOUT, 255: cycles to wait in REQ for inter before withdrawing and retrying; 8-bit counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- src  in  NSRC  peripheral requests; a rising edge sets pending
- mask_we  in  1  write strobe for mask register
- mask_wdata  in  NSRC  new mask value; 1 = source enabled
- mask  out  NSRC  current mask
- pending  out  NSRC  latched pending bits (masked and unmasked)
- inter  in  1  counter is servicing an interrupt
- eirq  in  1  counter end-of-interrupt pulse (RET from handler)
- irq1  out  1  code bit 0
- irq2  out  1  code bit 1
- irq3  out  1  code bit 2
- busy  out  1  FSM not in IDLE
- active  out  3  code currently presented or in service; 0 in IDLE

Behaviour:
- Reset (rst==0 at a clk edge):
  - mask=0, pending=0, synchronisers=0, irq1..3=0, active=0, busy=0, FSM=IDLE, timeout counter=0.
  - Reset mid-operation drops everything. No eirq is owed.
- Synchroniser and edge detect:
  - Each src[i] passes through SYNC_STAGES flops.
  - A rising edge is detected as sync_out=1 with previous=0.
  - pending[i] is set on the edge after detection. With SYNC_STAGES=2, pending[i] rises 3 edges after src[i] is first sampled high.
  - A level held high produces exactly one pending set.
- Mask:
  - On mask_we, mask<=mask_wdata on the next edge.
  - Masked sources still latch pending but do not compete.
  - A mask change does not withdraw a code already presented.
- Priority: highest index among (pending & mask) wins. Source i maps to code i+1, so src[6] gives code 7 and vector 8.
- IDLE:
  - Outputs irq=0.
  - If (pending & mask) is nonzero, register the winner into active, drive {irq3,irq2,irq1}=active, and go to REQ.
  - Latency: irq lines are high 1 cycle after pending is visible.
- REQ:
  - Hold the code stable and count cycles.
  - On inter==1: go to SVC, keep driving the code. The counter's latch ignores it once in service.
  - If the count reaches REQ_TIMEOUT without inter: drive irq=0, go to GAP, and keep pending set so the request retries.
- SVC:
  - Wait for eirq==1.
  - Then clear pending[active-1], drive irq=0, set active=0, and go to GAP.
  - If a new rising edge on the same source coincides with the clear, the set wins and pending stays 1.
- GAP:
  - Exactly one cycle with irq=0, so the counter's input buffer sees all-zero and rearms.
  - Then go to IDLE.
  - Minimum spacing between consecutive dispatches is 2 cycles (SVC→GAP→IDLE→REQ).
- eirq or inter arriving in IDLE or GAP is ignored.
- A higher-priority source arriving during REQ or SVC waits; there is no preemption, since the counter does not nest.
- busy=1 in REQ, SVC and GAP.
- All outputs are registered.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE=0, REQ=1, SVC=2, GAP=3.
  - Code width constant: 3.
  - Vector-base constant: 2, with code c mapping to vector c+1, kept consistent with the counter.
- One sub-module, irq_sync_edge: a parameterised SYNC_STAGES synchroniser plus rising-edge detector per source, instantiated over NSRC.
- Priority encoder and FSM live in the top module.

Test Plan:
- Reset check: hold rst=0 for 3 cycles with src=7'h7F → mask=0, pending=0, irq=000, busy=0. Release reset, pulse src[0] → pending=7'h01 but irq stays 000 because mask=0.
- Single dispatch: set mask=7'h7F, pulse src[2] → pending[2] rises 3 cycles later and active=3 one cycle after that. Assert inter → state SVC. Pulse eirq → pending=0, irq=000 for ≥1 cycle, busy falls 2 cycles after eirq.
- Priority: set src[1] and src[5] in the same cycle → code 6 first. After eirq and GAP, code 2 is presented.
- Timeout: present code 4 and never assert inter → irq drops to 000 at cycle 255, GAP lasts 1 cycle, code 4 is re-presented and pending[3] stays set.
- Re-edge during clear: give src[0] a new rising edge so its detection coincides with eirq for code 1 → pending[0] stays 1 and code 1 is re-dispatched after GAP.
- Mask and reset mid-service: in SVC for code 5, write mask=0 → active stays 5 until eirq. Then assert rst=0 in REQ for another source → next edge gives irq=000, pending=0, state IDLE.
